// File: rtl/pn_pkg.sv
// Shared types and constants for the PN token feeder: token layout, operator
// and mode codes, FSM state encoding and default sizing.
package pn_pkg;

  localparam int VAL_W        = 3;
  localparam int MODE_W       = 2;
  localparam int TOK_W        = VAL_W + 1;  // {operator flag, value}
  localparam int MAX_TOK_DEF  = 12;
  localparam int MAX_WAIT_DEF = 255;

  typedef enum logic [VAL_W-1:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MUL     = 3'd2,
    OP_ABS_SUM = 3'd3
  } op_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_PREFIX  = 2'd0,
    MODE_1       = 2'd1,
    MODE_2       = 2'd2,
    MODE_POSTFIX = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_DROP      = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_e;

  // An expression is accepted only when its token count is a non-zero
  // multiple of three that fits in the buffer.
  function automatic logic valid_len(input int n, input int max_tok);
    return (n >= 3) && (n <= max_tok) && ((n % 3) == 0);
  endfunction

endpackage

// File: rtl/pn_tok_buf.sv
// Token storage for one expression: DEPTH x TOK_W register file with one
// synchronous write port and one combinational read port.
module pn_tok_buf
  import pn_pkg::*;
#(
  parameter int DEPTH = MAX_TOK_DEF,
  parameter int AW    = $clog2(MAX_TOK_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [TOK_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [TOK_W-1:0] o_rdata
);

  logic [TOK_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pn_token_feeder.sv
// Collects one expression of tokens, checks its length, replays it to the PN
// stage as a contiguous burst and waits for the PN stage to finish.
module pn_token_feeder
  import pn_pkg::*;
#(
  parameter int MAX_TOK  = MAX_TOK_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic              tok_op,
  input  logic [VAL_W-1:0]  tok_val,
  input  logic              tok_last,
  input  logic [MODE_W-1:0] tok_mode,
  output logic [MODE_W-1:0] mode,
  output logic              operator,
  output logic [VAL_W-1:0]  in,
  output logic              in_valid,
  input  logic              pn_out_valid,
  output logic              busy,
  output logic              err
);

  // state       | meaning
  // S_IDLE      | no expression held; waiting for a first token
  // S_LOAD      | storing tokens until tok_last
  // S_DROP      | expression overflowed; swallowing tokens until tok_last
  // S_ISSUE     | replaying stored tokens, one per cycle
  // S_WAIT_DONE | waiting for PN-stage out_valid to fall, or timeout

  localparam int CW = $clog2(MAX_TOK + 2);
  localparam int AW = $clog2(MAX_TOK);
  localparam int WW = $clog2(MAX_WAIT + 1);

  state_e            r_state, w_next;
  logic [CW-1:0]     r_count, w_count_nxt, w_cnt_inc;
  logic [CW-1:0]     r_idx, w_idx_nxt;
  logic [WW-1:0]     r_wait, w_wait_nxt;
  logic              r_seen, w_seen_nxt;
  logic [MODE_W-1:0] r_mode_lat, w_mode_lat_nxt;

  logic              r_tok_ready, w_ready_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_err, w_err_nxt;
  logic              r_in_valid, w_iv_nxt;
  logic              r_operator, w_op_nxt;
  logic [VAL_W-1:0]  r_in, w_in_nxt;
  logic [MODE_W-1:0] r_mode, w_mode_nxt;

  logic              w_hs;
  logic              w_we;
  logic [AW-1:0]     w_waddr, w_raddr;
  logic [TOK_W-1:0]  w_wdata, w_rdata;

  assign w_hs      = tok_valid & r_tok_ready;
  assign w_cnt_inc = r_count + CW'(1);
  assign w_wdata   = {tok_op, tok_val};

  pn_tok_buf #(
    .DEPTH (MAX_TOK),
    .AW    (AW)
  ) u_tok_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_next         = r_state;
    w_count_nxt    = r_count;
    w_idx_nxt      = r_idx;
    w_wait_nxt     = r_wait;
    w_seen_nxt     = r_seen;
    w_mode_lat_nxt = r_mode_lat;
    w_we           = 1'b0;
    w_waddr        = AW'(r_count);
    w_raddr        = AW'(r_idx);
    w_err_nxt      = 1'b0;
    w_iv_nxt       = 1'b0;
    w_op_nxt       = 1'b0;
    w_in_nxt       = '0;
    w_mode_nxt     = '0;

    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          if (tok_last) begin
            w_err_nxt = 1'b1;
          end else begin
            w_we           = 1'b1;
            w_waddr        = '0;
            w_count_nxt    = CW'(1);
            w_mode_lat_nxt = tok_mode;
            w_next         = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          if (tok_last) begin
            if (valid_len(int'(w_cnt_inc), MAX_TOK)) begin
              // first burst token is presented on the cycle after tok_last
              w_we        = 1'b1;
              w_count_nxt = w_cnt_inc;
              w_raddr     = '0;
              w_iv_nxt    = 1'b1;
              w_op_nxt    = w_rdata[TOK_W-1];
              w_in_nxt    = w_rdata[VAL_W-1:0];
              w_mode_nxt  = r_mode_lat;
              w_idx_nxt   = CW'(1);
              w_next      = S_ISSUE;
            end else begin
              w_err_nxt   = 1'b1;
              w_count_nxt = '0;
              w_next      = S_IDLE;
            end
          end else if (int'(w_cnt_inc) > MAX_TOK) begin
            w_count_nxt = '0;
            w_next      = S_DROP;
          end else begin
            w_we        = 1'b1;
            w_count_nxt = w_cnt_inc;
          end
        end
      end
      S_DROP: begin
        if (w_hs && tok_last) begin
          w_err_nxt = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_idx == r_count) begin
          w_idx_nxt   = '0;
          w_count_nxt = '0;
          w_wait_nxt  = WW'(MAX_WAIT - 1);
          w_seen_nxt  = 1'b0;
          w_next      = S_WAIT_DONE;
        end else begin
          w_iv_nxt   = 1'b1;
          w_op_nxt   = w_rdata[TOK_W-1];
          w_in_nxt   = w_rdata[VAL_W-1:0];
          w_mode_nxt = r_mode_lat;
          w_idx_nxt  = r_idx + CW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (r_seen && !pn_out_valid) begin
          w_wait_nxt = '0;
          w_seen_nxt = 1'b0;
          w_next     = S_IDLE;
        end else if (r_wait == '0) begin
          w_err_nxt  = 1'b1;
          w_seen_nxt = 1'b0;
          w_next     = S_IDLE;
        end else begin
          w_wait_nxt = r_wait - WW'(1);
          w_seen_nxt = r_seen | pn_out_valid;
        end
      end
      default: w_next = S_IDLE;
    endcase

    // Holding tok_ready low during the err cycle keeps rejections apart.
    w_ready_nxt = ((w_next == S_IDLE) || (w_next == S_LOAD) || (w_next == S_DROP))
                  && !w_err_nxt;
    w_busy_nxt  = (w_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_idx       <= '0;
      r_wait      <= '0;
      r_seen      <= 1'b0;
      r_mode_lat  <= '0;
      r_tok_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_in_valid  <= 1'b0;
      r_operator  <= 1'b0;
      r_in        <= '0;
      r_mode      <= '0;
    end else begin
      r_state     <= w_next;
      r_count     <= w_count_nxt;
      r_idx       <= w_idx_nxt;
      r_wait      <= w_wait_nxt;
      r_seen      <= w_seen_nxt;
      r_mode_lat  <= w_mode_lat_nxt;
      r_tok_ready <= w_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
      r_in_valid  <= w_iv_nxt;
      r_operator  <= w_op_nxt;
      r_in        <= w_in_nxt;
      r_mode      <= w_mode_nxt;
    end
  end

  assign tok_ready = r_tok_ready;
  assign busy      = r_busy;
  assign err       = r_err;
  assign in_valid  = r_in_valid;
  assign operator  = r_operator;
  assign in        = r_in;
  assign mode      = r_mode;

endmodule

// File: tb/tb_pn_token_feeder.sv
// Bench for pn_token_feeder: expressions are planned as per-cycle output
// timelines and compared against the DUT every cycle.
module tb_pn_token_feeder;
  import pn_pkg::*;

  localparam int NCYC = 20000;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       err;
    logic       iv;
    logic       op;
    logic [2:0] val;
    logic [1:0] mode;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tok_valid = 1'b0, tok_op = 1'b0, tok_last = 1'b0, pn_out_valid = 1'b0;
  logic [2:0] tok_val = '0;
  logic [1:0] tok_mode = '0;
  logic       tok_ready, d_operator, in_valid, busy, err;
  logic [2:0] d_in;
  logic [1:0] d_mode;

  obs_t exp_q [NCYC];
  obs_t obs_q [NCYC];
  logic [3:0] fixed_tok [16];
  int   cyc = 0;
  int   checks = 0, errors = 0;
  bit   chk_en = 1'b0;

  pn_token_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_op       (tok_op),
    .tok_val      (tok_val),
    .tok_last     (tok_last),
    .tok_mode     (tok_mode),
    .mode         (d_mode),
    .operator     (d_operator),
    .in           (d_in),
    .in_valid     (in_valid),
    .pn_out_valid (pn_out_valid),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, expv);
    end
  endfunction

  always @(negedge clk) begin
    if (cyc < NCYC) begin
      obs_q[cyc] = obs_t'({tok_ready, busy, err, in_valid, d_operator, d_in, d_mode});
      if (chk_en && rst_n) begin
        chk("tok_ready", 8'(tok_ready),  8'(exp_q[cyc].ready));
        chk("busy",      8'(busy),       8'(exp_q[cyc].busy));
        chk("err",       8'(err),        8'(exp_q[cyc].err));
        chk("in_valid",  8'(in_valid),   8'(exp_q[cyc].iv));
        chk("operator",  8'(d_operator), 8'(exp_q[cyc].op));
        chk("in",        8'(d_in),       8'(exp_q[cyc].val));
        chk("mode",      8'(d_mode),     8'(exp_q[cyc].mode));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one n-token expression and writes the expected output timeline.
  // fixed: tokens from fixed_tok, no gaps, one-cycle pn_out_valid pulse right away.
  task automatic send_expr(input int n, input logic [1:0] md, input bit tmo,
                           input bit fixed, output int h_last);
    logic [3:0] toks[$];
    bit started;
    bit ok;
    int w1, p, len, end_c, g;
    started = 1'b0;
    h_last  = 0;
    if (cyc + 3 * n + 320 >= NCYC) begin
      $display("FAIL cycle_budget at cycle %0d: no room for expression", cyc);
      $fatal(1);
    end
    for (int i = 0; i < n; i++) begin
      g = fixed ? 0 : $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        tok_valid    = 1'b0;
        {tok_op, tok_val} = 4'($urandom);
        tok_last     = 1'($urandom);
        tok_mode     = 2'($urandom);
        pn_out_valid = 1'($urandom);
        if (started) exp_q[cyc].busy = 1'b1;
        tick();
      end
      tok_valid = 1'b1;
      tok_last  = (i == n - 1);
      tok_mode  = (i == 0) ? md : 2'($urandom);
      if (fixed) {tok_op, tok_val} = fixed_tok[i];
      else       {tok_op, tok_val} = 4'($urandom);
      pn_out_valid = 1'($urandom);
      toks.push_back({tok_op, tok_val});
      if (started) exp_q[cyc].busy = 1'b1;
      started = 1'b1;
      if (i == n - 1) h_last = cyc;
      tick();
    end
    tok_valid    = 1'b0;
    pn_out_valid = 1'b0;
    ok = (n % 3 == 0) && (n >= 3) && (n <= 12);
    if (!ok) begin
      exp_q[h_last+1].err   = 1'b1;
      exp_q[h_last+1].ready = 1'b0;
      tok_valid = 1'($urandom);
      tok_last  = 1'b1;
      tick();
      tok_valid = 1'b0;
    end else begin
      for (int k = 0; k < n; k++) begin
        exp_q[h_last+1+k].iv    = 1'b1;
        exp_q[h_last+1+k].op    = toks[k][3];
        exp_q[h_last+1+k].val   = toks[k][2:0];
        exp_q[h_last+1+k].mode  = md;
        exp_q[h_last+1+k].busy  = 1'b1;
        exp_q[h_last+1+k].ready = 1'b0;
      end
      w1 = h_last + n + 1;
      p = 0;
      len = 0;
      if (tmo) begin
        for (int c = w1; c < w1 + 255; c++) begin
          exp_q[c].busy  = 1'b1;
          exp_q[c].ready = 1'b0;
        end
        exp_q[w1+255].err   = 1'b1;
        exp_q[w1+255].ready = 1'b0;
        end_c = w1 + 256;
      end else begin
        p   = w1 + (fixed ? 0 : $urandom_range(0, 6));
        len = fixed ? 1 : $urandom_range(1, 3);
        for (int c = w1; c <= p + len; c++) begin
          exp_q[c].busy  = 1'b1;
          exp_q[c].ready = 1'b0;
        end
        end_c = p + len + 1;
      end
      while (cyc < end_c) begin
        tok_valid    = 1'($urandom);
        tok_last     = 1'($urandom);
        {tok_op, tok_val} = 4'($urandom);
        pn_out_valid = !tmo && (cyc >= p) && (cyc < p + len);
        tick();
      end
      tok_valid    = 1'b0;
      pn_out_valid = 1'b0;
    end
  endtask

  initial begin
    int h, nv, n;
    logic [1:0] md;
    for (int i = 0; i < NCYC; i++)
      exp_q[i] = '{ready: 1'b1, busy: 1'b0, err: 1'b0, iv: 1'b0, op: 1'b0,
                   val: 3'd0, mode: 2'd0};
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_valid", 8'(in_valid), 8'd0);
    chk("rst_busy",     8'(busy),     8'd0);
    chk("rst_err",      8'(err),      8'd0);
    chk("rst_outs",     8'({d_mode, d_operator, d_in}), 8'd0);
    tick();
    rst_n = 1'b1;
    #2;
    chk("rst_tok_ready", 8'(tok_ready), 8'd1);
    tick();
    chk_en = 1'b1;

    // Prefix mode 0: operator 2, operands 3, 4.
    fixed_tok[0] = 4'b1010; fixed_tok[1] = 4'b0011; fixed_tok[2] = 4'b0100;
    send_expr(3, MODE_PREFIX, 1'b0, 1'b1, h);
    chk("e37_t0",    8'({obs_q[h+1].iv, obs_q[h+1].op, obs_q[h+1].val}), 8'b11010);
    chk("e37_t1",    8'({obs_q[h+2].iv, obs_q[h+2].op, obs_q[h+2].val}), 8'b10011);
    chk("e37_t2",    8'({obs_q[h+3].iv, obs_q[h+3].op, obs_q[h+3].val}), 8'b10100);
    chk("e37_after", 8'(obs_q[h+4].iv), 8'd0);
    chk("e37_mode",  8'({obs_q[h+1].mode, obs_q[h+2].mode, obs_q[h+3].mode}), 8'd0);

    // 12-token postfix, pn_out_valid pulsed on the first wait cycle.
    for (int i = 0; i < 12; i++) fixed_tok[i] = 4'(i + 3);
    send_expr(12, MODE_POSTFIX, 1'b0, 1'b1, h);
    nv = 0;
    for (int c = h; c <= h + 14; c++) nv += int'(obs_q[c].iv);
    chk("e38_burst_len",  8'(nv), 8'd12);
    chk("e38_contig",     8'({obs_q[h+1].iv, obs_q[h+12].iv, obs_q[h+13].iv}), 8'b110);
    chk("e38_mode",       8'({obs_q[h+1].mode, obs_q[h+12].mode}), 8'b1111);
    chk("e38_busy_wait",  8'(obs_q[h+14].busy), 8'd1);
    chk("e38_busy_idle",  8'(obs_q[h+15].busy), 8'd0);

    // 5 tokens: rejected.
    send_expr(5, MODE_1, 1'b0, 1'b1, h);
    nv = 0;
    for (int c = h; c <= h + 3; c++) nv += int'(obs_q[c].iv);
    chk("e39_err",     8'({obs_q[h].err, obs_q[h+1].err, obs_q[h+2].err}), 8'b010);
    chk("e39_no_iv",   8'(nv), 8'd0);
    chk("e39_busy",    8'(obs_q[h+1].busy), 8'd0);

    // 14 tokens: overflow then rejection after tok_last.
    for (int i = 0; i < 14; i++) fixed_tok[i] = 4'(i);
    send_expr(14, MODE_2, 1'b0, 1'b1, h);
    chk("e40_err",     8'({obs_q[h].err, obs_q[h+1].err, obs_q[h+2].err}), 8'b010);
    chk("e40_busy_in_drop", 8'(obs_q[h].busy), 8'd1);

    // pn_out_valid never rises: timeout after 255 wait cycles.
    send_expr(3, MODE_1, 1'b1, 1'b1, h);
    chk("e41_no_err_early", 8'(obs_q[h+4+254].err), 8'd0);
    chk("e41_err",          8'(obs_q[h+4+255].err), 8'd1);
    chk("e41_busy",         8'({obs_q[h+4+254].busy, obs_q[h+4+255].busy}), 8'b10);

    for (int k = 0; k < 150 && cyc < NCYC - 400; k++) begin
      if ($urandom_range(0, 9) < 6) n = 3 * $urandom_range(1, 4);
      else                          n = $urandom_range(1, 16);
      md = 2'($urandom);
      send_expr(n, md, ($urandom_range(0, 19) == 0), 1'b0, h);
    end

    // Reset in the middle of a burst.
    chk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tok_valid = 1'b1;
      {tok_op, tok_val} = 4'($urandom);
      tok_last  = (i == 2);
      tok_mode  = MODE_1;
      tick();
    end
    tok_valid = 1'b0;
    tick();
    #2;
    chk("e42_iv_before", 8'(in_valid), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("e42_iv_async",  8'(in_valid), 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("e42_no_iv",  8'(in_valid),  8'd0);
      chk("e42_ready",  8'(tok_ready), 8'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pn_token_feeder.md
PN_TOKEN_FEEDER -- requirements
Module: pn_token_feeder

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port tok_valid  input  1  upstream token present.
REQ-004 SHALL have port tok_ready  output  1  feeder accepts token this cycle.
REQ-005 SHALL have port tok_op  input  1  1 = operator token, 0 = operand token.
REQ-006 SHALL have port tok_val  input  3  operator code (0 add, 1 sub, 2 mul, 3 abs-sum) or operand value 0..7.
REQ-007 SHALL have port tok_last  input  1  final token of one expression.
REQ-008 SHALL have port tok_mode  input  2  expression mode; sampled with first token only.
REQ-009 SHALL have port mode  output  2  mode presented to PN stage.
REQ-010 SHALL have port operator  output  1  token type presented to PN stage.
REQ-011 SHALL have port in  output  3  token value presented to PN stage.
REQ-012 SHALL have port in_valid  output  1  PN-stage token strobe.
REQ-013 SHALL have port pn_out_valid  input  1  out_valid returned from PN stage.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port err  output  1  one-cycle pulse on rejected expression.
REQ-016 SHALL have parameter MAX_TOK, default 12, maximum tokens per expression.
REQ-017 SHALL have parameter MAX_WAIT, default 255, cycles allowed in WAIT_DONE.

Function
REQ-018 SHALL implement states IDLE, LOAD, DROP, ISSUE, WAIT_DONE.
REQ-019 tok_ready SHALL be 1 in IDLE, LOAD, DROP; 0 in ISSUE, WAIT_DONE; handshake = tok_valid & tok_ready.
REQ-020 IDLE: on handshake store token at index 0, latch tok_mode, count=1, go LOAD; tok_last on this token -> err pulse, stay IDLE.
REQ-021 LOAD: each handshake stores token at index count, count+1; tokens never reordered or modified.
REQ-022 Handshake with tok_last: final count in {3,6,9,12} -> ISSUE next cycle; otherwise err pulse, buffer discarded, -> IDLE.
REQ-023 Handshake of token MAX_TOK+1 without prior tok_last -> DROP; DROP accepts and discards until tok_last handshake, then err pulse, -> IDLE.
REQ-024 ISSUE: in_valid SHALL be 1 for exactly count consecutive cycles, tokens in arrival order, first in_valid cycle = cycle after last-token handshake.
REQ-025 mode SHALL hold latched value for whole ISSUE burst; operator/in/mode SHALL be 0 whenever in_valid=0.
REQ-026 After final ISSUE token -> WAIT_DONE; in_valid=0.
REQ-027 WAIT_DONE: exit to IDLE on cycle after pn_out_valid falls (seen 1 then 0).
REQ-028 WAIT_DONE: wait counter reaching MAX_WAIT without that falling edge -> err pulse, -> IDLE.
REQ-029 pn_out_valid outside WAIT_DONE SHALL be ignored.
REQ-030 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-031 err SHALL never be high for two consecutive cycles; back-to-back rejections SHALL be separated by at least one IDLE cycle.

Reset
REQ-032 rst_n low SHALL force state IDLE, count 0, wait counter 0, buffer cleared.
REQ-033 rst_n low SHALL force mode=0, operator=0, in=0, in_valid=0, err=0, busy=0; tok_ready=1 after release.
REQ-034 Reset during ISSUE SHALL drop in_valid asynchronously; the remaining burst SHALL NOT resume.

Structure
REQ-035 Shared package pn_pkg SHALL hold operator codes, mode codes, MAX_TOK default, state encoding, token width.
REQ-036 Token storage SHALL be sub-module pn_tok_buf: MAX_TOK x 4-bit register file, one write port, one read port.

Verification
REQ-037 Prefix mode 0, tokens {op 2, 3, 4} with tok_last on 3rd -> in_valid 3 cycles from next cycle: (1,2),(0,3),(0,4), mode=0 throughout.
REQ-038 12-token postfix mode 3 -> 12-cycle contiguous burst, mode=3; pn_out_valid pulse 1 cycle then low -> IDLE, busy=0 next cycle.
REQ-039 5 tokens with tok_last -> err 1 cycle, in_valid never asserted, busy=0.
REQ-040 14 tokens, tok_last on 14th -> DROP after 13th, err on cycle after 14th, no in_valid.
REQ-041 pn_out_valid held 0 in WAIT_DONE -> err after 255 cycles, -> IDLE.
REQ-042 rst_n asserted on 2nd ISSUE cycle -> in_valid=0 immediately; after release tok_ready=1, no further in_valid.
